// File: rtl/i_fetch_pkg.sv
// Shared constants for the xriscv instruction fetch stage.
// Holds the default widths, the reset vector and the instruction size.
package i_fetch_pkg;

  localparam int DEFAULT_XLEN     = 32;
  localparam int DEFAULT_ADDR_LEN = 14;

  localparam logic [DEFAULT_ADDR_LEN-1:0] RESET_VECTOR = 14'h0000;

  localparam int INST_SIZE = 4;

endpackage

// File: rtl/i_skid.sv
// One-entry {pc, data} holding register.
// Clear wins over load, so a redirect always empties the entry.
module i_skid #(
  parameter int W_PC   = 14,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [W_PC-1:0]   pc_i,
  input  logic [W_DATA-1:0] data_i,
  output logic              vld_o,
  output logic [W_PC-1:0]   pc_o,
  output logic [W_DATA-1:0] data_o
);

  logic              vld_q;
  logic [W_PC-1:0]   pc_q;
  logic [W_DATA-1:0] data_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      vld_q  <= 1'b0;
      pc_q   <= '0;
      data_q <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      pc_q   <= pc_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign pc_o   = pc_q;
  assign data_o = data_q;

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch stage: owns the PC, issues synchronous-read fetches and
// hands words to decode over valid/ready, with a skid entry to absorb stalls.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter int                  XLEN     = DEFAULT_XLEN,
  parameter int                  ADDR_LEN = DEFAULT_ADDR_LEN,
  parameter logic [ADDR_LEN-1:0] RESET_PC = ADDR_LEN'(RESET_VECTOR)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                fetch_en,
  output logic [ADDR_LEN-1:0] addr,
  input  logic [XLEN-1:0]     rd_data,
  input  logic                redirect_vld,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  output logic                inst_vld,
  input  logic                inst_rdy,
  output logic [XLEN-1:0]     inst,
  output logic [ADDR_LEN-1:0] inst_pc
);

  localparam logic [ADDR_LEN-1:0] PC_INC = ADDR_LEN'(INST_SIZE);

  logic [ADDR_LEN-1:0] req_pc_q, req_pc_d;
  logic [ADDR_LEN-1:0] resp_pc_q, resp_pc_d;
  logic                resp_vld_q, resp_vld_d;
  logic [ADDR_LEN-1:0] redirect_tgt;
  logic                stall;
  logic                issue;
  logic                skid_load;
  logic                skid_clr;
  logic                skid_vld;
  logic [ADDR_LEN-1:0] skid_pc;
  logic [XLEN-1:0]     skid_data;
  logic                unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[ADDR_LEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A word is stuck whenever something is presented but decode is not taking it;
  // a draining skid entry does not block the next issue.
  assign stall = (resp_vld_q | skid_vld) & ~inst_rdy;
  assign issue = fetch_en & ~stall;

  always_comb begin
    addr       = req_pc_q;
    req_pc_d   = req_pc_q;
    resp_vld_d = 1'b0;
    resp_pc_d  = resp_pc_q;
    skid_load  = 1'b0;
    skid_clr   = 1'b0;
    if (redirect_vld) begin
      addr       = redirect_tgt;
      req_pc_d   = redirect_tgt + PC_INC;
      resp_vld_d = 1'b1;
      resp_pc_d  = redirect_tgt;
      skid_clr   = 1'b1;
    end else begin
      skid_load = resp_vld_q & ~inst_rdy & ~skid_vld;
      skid_clr  = skid_vld & inst_rdy;
      if (issue) begin
        resp_vld_d = 1'b1;
        resp_pc_d  = req_pc_q;
        req_pc_d   = req_pc_q + PC_INC;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_pc_q   <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      resp_vld_q <= 1'b0;
    end else begin
      req_pc_q   <= req_pc_d;
      resp_pc_q  <= resp_pc_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  i_skid #(
    .W_PC   (ADDR_LEN),
    .W_DATA (XLEN)
  ) u_skid (
    .clk    (clk),
    .rstb   (rstb),
    .load_i (skid_load),
    .clr_i  (skid_clr),
    .pc_i   (resp_pc_q),
    .data_i (rd_data),
    .vld_o  (skid_vld),
    .pc_o   (skid_pc),
    .data_o (skid_data)
  );

  assign inst_vld = (skid_vld | resp_vld_q) & ~redirect_vld;
  assign inst     = skid_vld ? skid_data : rd_data;
  assign inst_pc  = skid_vld ? skid_pc   : resp_pc_q;

endmodule

// File: tb/tb_i_fetch.sv
// Directed bench for i_fetch with a synchronous-read instruction memory model.
module tb_i_fetch;

  logic        clk;
  logic        rstb;
  logic        fetch_en;
  logic [13:0] addr;
  logic [31:0] rd_data;
  logic        redirect_vld;
  logic [13:0] redirect_pc;
  logic        inst_vld;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [13:0] inst_pc;

  int checks;
  int errors;

  i_fetch dut (
    .clk          (clk),
    .rstb         (rstb),
    .fetch_en     (fetch_en),
    .addr         (addr),
    .rd_data      (rd_data),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .inst_vld     (inst_vld),
    .inst_rdy     (inst_rdy),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each word encodes its own address so a dropped or duplicated word shows up.
  function automatic logic [31:0] memWord(input logic [13:0] a);
    return {2'b00, a, 16'h0013};
  endfunction

  always @(posedge clk) rd_data <= memWord(addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy,
                               input logic rv, input logic [13:0] rpc);
    @(negedge clk);
    fetch_en     = fe;
    inst_rdy     = rdy;
    redirect_vld = rv;
    redirect_pc  = rpc;
    #1;
  endtask

  task automatic expectInst(input string tag, input logic [13:0] pc,
                            input logic [13:0] nextAddr);
    checkOutput({tag, "_vld"},  {31'd0, inst_vld}, 32'd1);
    checkOutput({tag, "_pc"},   {18'd0, inst_pc},  {18'd0, pc});
    checkOutput({tag, "_inst"}, inst,              memWord(pc));
    checkOutput({tag, "_addr"}, {18'd0, addr},     {18'd0, nextAddr});
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rstb         = 1'b0;
    fetch_en     = 1'b1;
    inst_rdy     = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = 14'h0;

    @(negedge clk);
    #1;
    checkOutput("rst_addr", {18'd0, addr},     32'h0);
    checkOutput("rst_vld",  {31'd0, inst_vld}, 32'd0);
    checkOutput("rst_pc",   {18'd0, inst_pc},  32'h0);

    @(negedge clk);
    rstb = 1'b1;
    #1;
    checkOutput("rel_addr", {18'd0, addr},     32'h0);
    checkOutput("rel_vld",  {31'd0, inst_vld}, 32'd0);

    // Streaming at one word per cycle
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("seq0", 14'h0000, 14'h0004);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("seq4", 14'h0004, 14'h0008);

    // Decode stalls for three cycles while the word at 0x8 is presented
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("stall0", 14'h0008, 14'h000C);
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("stall1", 14'h0008, 14'h000C);
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("stall2", 14'h0008, 14'h000C);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("drain", 14'h0008, 14'h000C);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("afterDrain", 14'h000C, 14'h0010);

    // Fill the skid, then redirect to a misaligned RAM target
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("fillSkid", 14'h0010, 14'h0014);
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("heldSkid", 14'h0010, 14'h0014);
    applyStimulus(1'b1, 1'b0, 1'b1, 14'h2003);
    checkOutput("redir_addr", {18'd0, addr},     32'h2000);
    checkOutput("redir_vld",  {31'd0, inst_vld}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("redirTgt", 14'h2000, 14'h2004);

    // PC wraps from the top of the address space to zero
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h3FFC);
    checkOutput("wrapRedir_addr", {18'd0, addr},     32'h3FFC);
    checkOutput("wrapRedir_vld",  {31'd0, inst_vld}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("wrapTop", 14'h3FFC, 14'h0000);

    // fetch_en drops while the word at 0x0 is in flight
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0);
    expectInst("feOff", 14'h0000, 14'h0004);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0);
    checkOutput("feIdle_vld",  {31'd0, inst_vld}, 32'd0);
    checkOutput("feIdle_addr", {18'd0, addr},     32'h0004);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    checkOutput("feOn_vld",  {31'd0, inst_vld}, 32'd0);
    checkOutput("feOn_addr", {18'd0, addr},     32'h0004);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("feResume", 14'h0004, 14'h0008);

    // Asynchronous reset while a word sits in the skid
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("preRst", 14'h0008, 14'h000C);
    applyStimulus(1'b1, 1'b0, 1'b0, 14'h0);
    expectInst("heldRst", 14'h0008, 14'h000C);
    #1;
    rstb = 1'b0;
    #1;
    checkOutput("midRst_vld",  {31'd0, inst_vld}, 32'd0);
    checkOutput("midRst_addr", {18'd0, addr},     32'h0);
    checkOutput("midRst_pc",   {18'd0, inst_pc},  32'h0);
    @(negedge clk);
    rstb     = 1'b1;
    inst_rdy = 1'b1;
    #1;
    checkOutput("reRel_vld",  {31'd0, inst_vld}, 32'd0);
    checkOutput("reRel_addr", {18'd0, addr},     32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0);
    expectInst("restart", 14'h0000, 14'h0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
